id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register for the 64-bit RISC-V core.
- Takes the decoded instruction fields and register-file read data.
- Generates the 4-bit ALU control code and selects operands A and B.
- Registers the results, with control bits, behind a valid/ready handshake; the registered outputs drive the execute-stage ALU directly.

---
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control and operands, registers them behind valid/ready.
// Optional operand forwarding from MEM/WB is enabled with `define ID_EX_FORWARD_EN.
module id_ex_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
`ifdef ID_EX_FORWARD_EN
  input  logic            fwd_mem_valid,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [2:0]      ex_funct3,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] a_c, b_c;
  logic [3:0]      alu_c, arith_alu;
  logic            rw_c, mr_c, mw_c, br_c, jp_c, ill_c;
  logic            load;

`ifdef ID_EX_FORWARD_EN
  // MEM result is newer than WB, so it wins; x0 is never forwarded
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    if (in_rs1 != 5'd0 && fwd_mem_valid && fwd_mem_rd == in_rs1)     rs1_val = fwd_mem_data;
    else if (in_rs1 != 5'd0 && fwd_wb_valid && fwd_wb_rd == in_rs1) rs1_val = fwd_wb_data;
    if (in_rs2 != 5'd0 && fwd_mem_valid && fwd_mem_rd == in_rs2)     rs2_val = fwd_mem_data;
    else if (in_rs2 != 5'd0 && fwd_wb_valid && fwd_wb_rd == in_rs2) rs2_val = fwd_wb_data;
  end
`else
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;
`endif

  // funct3 map shared by R- and I-type; SUB only exists for R-type
  always_comb begin
    arith_alu = ALU_ADD;
    unique case (in_funct3)
      3'b000: arith_alu = (in_opcode == OP_R && in_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: arith_alu = ALU_SLL;
      3'b010: arith_alu = ALU_SLT;
      3'b011: arith_alu = ALU_SLTU;
      3'b100: arith_alu = ALU_XOR;
      3'b101: arith_alu = in_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: arith_alu = ALU_OR;
      3'b111: arith_alu = ALU_AND;
      default: arith_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    a_c   = rs1_val;
    b_c   = rs2_val;
    alu_c = ALU_ADD;
    rw_c  = 1'b0;
    mr_c  = 1'b0;
    mw_c  = 1'b0;
    br_c  = 1'b0;
    jp_c  = 1'b0;
    ill_c = 1'b0;
    case (in_opcode)
      OP_R:     begin alu_c = arith_alu; rw_c = 1'b1; end
      OP_I:     begin alu_c = arith_alu; b_c = in_imm; rw_c = 1'b1; end
      OP_LOAD:  begin b_c = in_imm; mr_c = 1'b1; rw_c = 1'b1; end
      OP_STORE: begin b_c = in_imm; mw_c = 1'b1; end
      OP_BRANCH: begin
        br_c = 1'b1;
        case (in_funct3[2:1])
          2'b00:   alu_c = ALU_SUB;
          2'b10:   alu_c = ALU_SLT;
          2'b11:   alu_c = ALU_SLTU;
          default: begin br_c = 1'b0; ill_c = 1'b1; end
        endcase
      end
      OP_LUI:   begin a_c = '0; b_c = in_imm; rw_c = 1'b1; end
      OP_AUIPC: begin a_c = in_pc; b_c = in_imm; rw_c = 1'b1; end
      OP_JAL, OP_JALR: begin
        a_c  = in_pc;
        b_c  = XLEN'(4);
        jp_c = 1'b1;
        rw_c = 1'b1;
      end
      default:  ill_c = 1'b1;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // flush has priority over load and drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_a           <= '0;
      ex_b           <= '0;
      ex_alu_control <= '0;
      ex_rs2_data    <= '0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_funct3      <= '0;
      ex_illegal     <= 1'b0;
    end else if (load) begin
      ex_a           <= a_c;
      ex_b           <= b_c;
      ex_alu_control <= alu_c;
      ex_rs2_data    <= rs2_val;
      ex_rd          <= in_rd;
      ex_reg_write   <= rw_c && (in_rd != 5'd0);
      ex_mem_read    <= mr_c;
      ex_mem_write   <= mw_c;
      ex_branch      <= br_c;
      ex_jump        <= jp_c;
      ex_funct3      <= in_funct3;
      ex_illegal     <= ill_c;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected entries, a monitor pops on each handshake.
// Define ID_EX_FORWARD_EN on both files to also exercise the forwarding path.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] ex_a, ex_b, ex_rs2_data;
  logic [3:0]      ex_alu_control;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal;
  logic [2:0]      ex_funct3;
`ifdef ID_EX_FORWARD_EN
  logic            fwd_mem_valid, fwd_wb_valid;
  logic [4:0]      fwd_mem_rd, fwd_wb_rd;
  logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
`ifdef ID_EX_FORWARD_EN
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic [XLEN-1:0] a, b, rs2;
    logic [3:0]      alu;
    logic [4:0]      rd;
    logic            rw, mr, mw, br, jp;
    logic [2:0]      f3;
    logic            ill;
  } exp_t;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic [XLEN-1:0] pc, r1d, r2d, imm;
    logic [4:0]      rs1, rs2, rd;
  } in_t;

  exp_t  sb[$];
  string sb_name[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic in_t mkin(logic [6:0] op, logic [2:0] f3, logic f7, logic [XLEN-1:0] pc,
                               logic [XLEN-1:0] r1d, logic [XLEN-1:0] r2d, logic [XLEN-1:0] imm,
                               logic [4:0] rd);
    in_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.pc = pc; v.r1d = r1d; v.r2d = r2d; v.imm = imm;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = rd;
    return v;
  endfunction

  function automatic exp_t mkex(logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [3:0] alu,
                                logic [XLEN-1:0] rs2, logic [4:0] rd, logic rw, logic mr,
                                logic mw, logic br, logic jp, logic [2:0] f3, logic ill);
    exp_t e;
    e.a = a; e.b = b; e.alu = alu; e.rs2 = rs2; e.rd = rd; e.rw = rw; e.mr = mr;
    e.mw = mw; e.br = br; e.jp = jp; e.f3 = f3; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // drive one entry and wait until it is accepted; in_valid stays high for back-to-back use
  task automatic send(input string nm, input in_t v, input exp_t e, input logic fl,
                      output int waited);
    logic done = 1'b0;
    in_opcode = v.op; in_funct3 = v.f3; in_funct7b5 = v.f7; in_pc = v.pc;
    in_rs1_data = v.r1d; in_rs2_data = v.r2d; in_imm = v.imm;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
    in_valid = 1'b1;
    flush = fl;
    waited = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!fl) begin
          sb.push_back(e);
          sb_name.push_back(nm);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s accept timeout: got in_ready=0 expected 1 within 20 cycles", nm);
      flush = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: compare every handshaked entry against the scoreboard head
  always @(negedge clk) begin
    exp_t  got, e;
    string nm;
    if (rst_n && out_valid && out_ready) begin
      got = mkex(ex_a, ex_b, ex_alu_control, ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read,
                 ex_mem_write, ex_branch, ex_jump, ex_funct3, ex_illegal);
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected entry: got %h expected no entry", got);
      end else begin
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        if (got === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, e);
      end
    end
  end

  initial begin
    int   w;
    in_t  v;
    exp_t e;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
`ifdef ID_EX_FORWARD_EN
    fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
`endif
    #12;
    chk("reset out_valid", XLEN'(out_valid), '0);
    chk("reset ex_a", ex_a, '0);
    chk("reset in_ready", XLEN'(in_ready), XLEN'(1));
    @(posedge clk); #1 rst_n = 1'b1;

    // arithmetic decode, back-to-back
    send("sub", mkin(7'b0110011, 3'b000, 1'b1, 64'h0, 64'd10, 64'd3, 64'h0, 5'd5),
         mkex(64'd10, 64'd3, 4'b0110, 64'd3, 5'd5, 1, 0, 0, 0, 0, 3'b000, 0), 1'b0, w);
    send("srai", mkin(7'b0010011, 3'b101, 1'b1, 64'h0, 64'hF0, 64'h77, 64'd4, 5'd6),
         mkex(64'hF0, 64'd4, 4'b0101, 64'h77, 5'd6, 1, 0, 0, 0, 0, 3'b101, 0), 1'b0, w);
    send("addi f7b5", mkin(7'b0010011, 3'b000, 1'b1, 64'h0, 64'd20, 64'd9, 64'd4, 5'd6),
         mkex(64'd20, 64'd4, 4'b0010, 64'd9, 5'd6, 1, 0, 0, 0, 0, 3'b000, 0), 1'b0, w);
    send("xor", mkin(7'b0110011, 3'b100, 1'b0, 64'h0, 64'hFF, 64'h0F, 64'h0, 5'd7),
         mkex(64'hFF, 64'h0F, 4'b1001, 64'h0F, 5'd7, 1, 0, 0, 0, 0, 3'b100, 0), 1'b0, w);
    send("sra", mkin(7'b0110011, 3'b101, 1'b1, 64'h0, 64'h80, 64'd2, 64'h0, 5'd8),
         mkex(64'h80, 64'd2, 4'b0101, 64'd2, 5'd8, 1, 0, 0, 0, 0, 3'b101, 0), 1'b0, w);
    send("sltiu", mkin(7'b0010011, 3'b011, 1'b0, 64'h0, 64'd5, 64'd1, 64'd9, 5'd9),
         mkex(64'd5, 64'd9, 4'b0111, 64'd1, 5'd9, 1, 0, 0, 0, 0, 3'b011, 0), 1'b0, w);
    send("load", mkin(7'b0000011, 3'b011, 1'b0, 64'h0, 64'h1000, 64'h5, 64'd8, 5'd9),
         mkex(64'h1000, 64'd8, 4'b0010, 64'h5, 5'd9, 1, 1, 0, 0, 0, 3'b011, 0), 1'b0, w);
    send("store", mkin(7'b0100011, 3'b011, 1'b0, 64'h0, 64'h2000, 64'hDEAD, 64'd16, 5'd3),
         mkex(64'h2000, 64'd16, 4'b0010, 64'hDEAD, 5'd3, 0, 0, 1, 0, 0, 3'b011, 0), 1'b0, w);
    send("lui", mkin(7'b0110111, 3'b000, 1'b0, 64'h44, 64'h99, 64'h0, 64'h12345000, 5'd10),
         mkex(64'h0, 64'h12345000, 4'b0010, 64'h0, 5'd10, 1, 0, 0, 0, 0, 3'b000, 0), 1'b0, w);
    send("auipc", mkin(7'b0010111, 3'b000, 1'b0, 64'h400, 64'h99, 64'h0, 64'h1000, 5'd11),
         mkex(64'h400, 64'h1000, 4'b0010, 64'h0, 5'd11, 1, 0, 0, 0, 0, 3'b000, 0), 1'b0, w);
    send("jal", mkin(7'b1101111, 3'b000, 1'b0, 64'h800, 64'h99, 64'h0, 64'h40, 5'd1),
         mkex(64'h800, 64'd4, 4'b0010, 64'h0, 5'd1, 1, 0, 0, 0, 1, 3'b000, 0), 1'b0, w);
    send("beq", mkin(7'b1100011, 3'b000, 1'b0, 64'h0, 64'd7, 64'd7, 64'h20, 5'd0),
         mkex(64'd7, 64'd7, 4'b0110, 64'd7, 5'd0, 0, 0, 0, 1, 0, 3'b000, 0), 1'b0, w);
    send("bge", mkin(7'b1100011, 3'b101, 1'b0, 64'h0, 64'd7, 64'd3, 64'h20, 5'd0),
         mkex(64'd7, 64'd3, 4'b1000, 64'd3, 5'd0, 0, 0, 0, 1, 0, 3'b101, 0), 1'b0, w);
    send("illegal", mkin(7'b0001111, 3'b000, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 5'd4),
         mkex(64'h0, 64'h0, 4'b0010, 64'h0, 5'd4, 0, 0, 0, 0, 0, 3'b000, 1), 1'b0, w);
    send("addi rd0", mkin(7'b0010011, 3'b000, 1'b0, 64'h0, 64'd1, 64'd2, 64'd3, 5'd0),
         mkex(64'd1, 64'd3, 4'b0010, 64'd2, 5'd0, 0, 0, 0, 0, 0, 3'b000, 0), 1'b0, w);
    idle(2);

    // stall: entry held with out_ready low while a new one waits
    out_ready = 1'b0;
    send("stall e1", mkin(7'b0110011, 3'b110, 1'b0, 64'h0, 64'hA0, 64'h0B, 64'h0, 5'd12),
         mkex(64'hA0, 64'h0B, 4'b0001, 64'h0B, 5'd12, 1, 0, 0, 0, 0, 3'b110, 0), 1'b0, w);
    in_opcode = 7'b0110011; in_funct3 = 3'b111; in_rs1_data = 64'h3C; in_rs2_data = 64'h0F;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall in_ready", XLEN'(in_ready), '0);
      chk("stall ex_a", ex_a, 64'hA0);
      chk("stall out_valid", XLEN'(out_valid), XLEN'(1));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send("and", mkin(7'b0110011, 3'b111, 1'b0, 64'h0, 64'h3C, 64'h0F, 64'h0, 5'd13),
         mkex(64'h3C, 64'h0F, 4'b0000, 64'h0F, 5'd13, 1, 0, 0, 0, 0, 3'b111, 0), 1'b0, w);
    chk("resume wait", XLEN'(w), '0);
    send("sll", mkin(7'b0110011, 3'b001, 1'b0, 64'h0, 64'h1, 64'd4, 64'h0, 5'd14),
         mkex(64'h1, 64'd4, 4'b0011, 64'd4, 5'd14, 1, 0, 0, 0, 0, 3'b001, 0), 1'b0, w);
    chk("b2b wait 1", XLEN'(w), '0);
    send("slt", mkin(7'b0110011, 3'b010, 1'b0, 64'h0, 64'h2, 64'd9, 64'h0, 5'd15),
         mkex(64'h2, 64'd9, 4'b1000, 64'd9, 5'd15, 1, 0, 0, 0, 0, 3'b010, 0), 1'b0, w);
    chk("b2b wait 2", XLEN'(w), '0);
    idle(2);

    // flush discards a simultaneous load
    send("bltu flushed", mkin(7'b1100011, 3'b110, 1'b0, 64'h0, 64'd1, 64'd2, 64'h0, 5'd0),
         mkex('0, '0, 4'b0000, '0, 5'd0, 0, 0, 0, 0, 0, 3'b000, 0), 1'b1, w);
    in_valid = 1'b0;
    chk("flush out_valid", XLEN'(out_valid), '0);
    send("bltu", mkin(7'b1100011, 3'b110, 1'b0, 64'h0, 64'd1, 64'd2, 64'h0, 5'd0),
         mkex(64'd1, 64'd2, 4'b0111, 64'd2, 5'd0, 0, 0, 0, 1, 0, 3'b110, 0), 1'b0, w);
    idle(2);

`ifdef ID_EX_FORWARD_EN
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd7; fwd_mem_data = 64'hAAAA;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd7; fwd_wb_data = 64'hBBBB;
    v = mkin(7'b0010011, 3'b000, 1'b0, 64'h0, 64'h111, 64'h222, 64'd1, 5'd8);
    v.rs1 = 5'd7;
    send("fwd mem", v, mkex(64'hAAAA, 64'd1, 4'b0010, 64'h222, 5'd8, 1, 0, 0, 0, 0, 3'b000, 0),
         1'b0, w);
    idle(2);
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
`endif

    // reset while an entry is stalled
    out_ready = 1'b0;
    v = mkin(7'b0110011, 3'b000, 1'b0, 64'h0, 64'h55, 64'h66, 64'h0, 5'd5);
    e = mkex(64'h55, 64'h66, 4'b0010, 64'h66, 5'd5, 1, 0, 0, 0, 0, 3'b000, 0);
    send("pre-reset", v, e, 1'b0, w);
    in_valid = 1'b0;
    chk("pre-reset out_valid", XLEN'(out_valid), XLEN'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", XLEN'(out_valid), '0);
    chk("async reset ex_a", ex_a, '0);
    chk("async reset ex_alu", XLEN'(ex_alu_control), '0);
    chk("async reset ex_reg_write", XLEN'(ex_reg_write), '0);
    sb.delete();
    sb_name.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", XLEN'(in_ready), XLEN'(1));

    repeat (3) @(negedge clk);
    chk("scoreboard drained", XLEN'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
